// File: rtl/test_ram_requester.sv
// ---------------------------------------------------------------------------
// test_ram_requester
//
// Bus initiator for the TestRam slave port. A CPU-side request (byte or
// 16-bit little-endian word, read or write) is turned into one or two
// sequential byte accesses on the RAM port. Each access waits for the RAM's
// one-cycle data_ready pulse. An access phase that waits too long is aborted
// and the request finishes with an error response.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   req_valid/ready    : request handshake (ready only while idle)
//   req_we, req_wide   : write select, word select
//   req_addr           : byte address of the low byte
//   req_wdata          : write data, low byte -> addr, high byte -> addr+1
//   rsp_valid          : one-cycle completion pulse
//   rsp_rdata, rsp_err : response data and timeout flag
//   ram_we, ram_addr, ram_data_in   : drive TestRam
//   ram_data_out, ram_data_ready    : from TestRam
// ---------------------------------------------------------------------------
module test_ram_requester #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic                  req_wide,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [15:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [15:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   input  logic                  ram_data_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC_LO = 2'd1,
      ACC_HI = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t                state_q;
   logic                  we_q;
   logic                  wide_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [15:0]           wdata_q;
   logic [7:0]            lo_q;
   logic [7:0]            cnt_q;

   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic [15:0]           rsp_rdata_q;
   logic                  rsp_err_q;
   logic                  ram_we_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [DATA_WIDTH-1:0] ram_data_in_q;

   logic [ADDR_WIDTH-1:0] addr_hi_d;
   logic [7:0]            cnt_d;
   logic                  timeout_s;

   // High-byte address (wraps at the top of the space), counter increment and limit compare
   always_comb begin
      addr_hi_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      cnt_d     = cnt_q + 8'd1;
      timeout_s = (cnt_q >= TIMEOUT_LIMIT);
   end

   // Request sequencer: state, latched request, RAM drive and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         wide_q        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= 16'h0000;
         lo_q          <= 8'h00;
         cnt_q         <= 8'h00;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 16'h0000;
         rsp_err_q     <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_data_in_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  we_q          <= req_we;
                  wide_q        <= req_wide;
                  addr_q        <= req_addr;
                  wdata_q       <= req_wdata;
                  cnt_q         <= 8'h00;
                  ram_addr_q    <= req_addr;
                  ram_we_q      <= req_we;
                  ram_data_in_q <= req_wdata[7:0];
                  req_ready_q   <= 1'b0;
                  state_q       <= ACC_LO;
               end else begin
                  state_q <= IDLE;
               end
            end
            ACC_LO: begin
               // ready is checked before the limit so a same-cycle answer still succeeds
               if (ram_data_ready) begin
                  cnt_q <= 8'h00;
                  lo_q  <= we_q ? 8'h00 : ram_data_out;
                  if (wide_q) begin
                     ram_addr_q    <= addr_hi_d;
                     ram_data_in_q <= wdata_q[15:8];
                     state_q       <= ACC_HI;
                  end else begin
                     ram_we_q    <= 1'b0;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_rdata_q <= we_q ? 16'h0000 : {8'h00, ram_data_out};
                     state_q     <= RESP;
                  end
               end else if (timeout_s) begin
                  // abort the whole request, the high byte is never attempted
                  ram_we_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 16'h0000;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ACC_HI: begin
               if (ram_data_ready) begin
                  cnt_q       <= 8'h00;
                  ram_we_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= we_q ? 16'h0000 : {ram_data_out, lo_q};
                  state_q     <= RESP;
               end else if (timeout_s) begin
                  ram_we_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 16'h0000;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RESP: begin
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= 16'h0000;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               ram_we_q    <= 1'b0;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= 16'h0000;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign ram_we      = ram_we_q;
   assign ram_addr    = ram_addr_q;
   assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_test_ram_requester.sv
module tb_test_ram_requester;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we, req_wide;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_wdata;
   logic          rsp_valid, rsp_err;
   logic [15:0]   rsp_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_in, ram_data_out;
   logic          ram_data_ready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   test_ram_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wide(req_wide),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out), .ram_data_ready(ram_data_ready)
   );

   // RAM model: answers each access phase after ram_wait idle cycles
   logic [7:0]  mem [0:65535];
   int          ram_wait = 2;
   int          wait_cnt = 0;
   int          acc_count = 0;
   int          we_violations = 0;
   logic [15:0] last_acc_addr = 16'h0000;

   always @(negedge clk) begin
      if (rst !== 1'b1 && req_ready === 1'b0 && rsp_valid === 1'b0) begin
         if (wait_cnt >= ram_wait) begin
            if (ram_we === 1'b1) mem[ram_addr] = ram_data_in;
            ram_data_out   = mem[ram_addr];
            ram_data_ready = 1'b1;
            last_acc_addr  = ram_addr;
            acc_count      = acc_count + 1;
            wait_cnt       = 0;
         end else begin
            ram_data_ready = 1'b0;
            wait_cnt       = wait_cnt + 1;
         end
      end else begin
         ram_data_ready = 1'b0;
         wait_cnt       = 0;
         if (ram_we === 1'b1) we_violations = we_violations + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request, return response and latency (cycles after the acceptance edge)
   task automatic do_req(input logic we, input logic wide, input logic [15:0] addr,
                         input logic [15:0] wdata, output logic [15:0] rdata,
                         output logic err, output int lat, output int nacc);
      int a0;
      a0 = acc_count;
      lat = -1; rdata = 16'hxxxx; err = 1'bx;
      @(negedge clk);
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
      req_valid = 1'b1; req_we = we; req_wide = wide; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            lat = c; rdata = rsp_rdata; err = rsp_err;
            break;
         end
      end
      #1 nacc = acc_count - a0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err, ram_we, rsp_rdata, ram_addr, ram_data_in} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_values: got rdy=%b v=%b e=%b we=%b rd=%h a=%h di=%h, want 1 0 0 0 0000 0000 00",
                  req_ready, rsp_valid, rsp_err, ram_we, rsp_rdata, ram_addr, ram_data_in);
      end
      rst = 1'b0;
   endtask

   task automatic test_byte();
      logic [15:0] rd; logic er; int lat, na;
      ram_wait = 2;
      do_req(1'b1, 1'b0, 16'h0010, 16'h005A, rd, er, lat, na);
      n_checks++; if ({er, rd} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL byte_wr_rsp: got err=%b rdata=%h want 0 0000", er, rd); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL byte_wr_latency: got %0d want 4", lat); end
      n_checks++; if (na !== 1) begin n_fail++; $display("FAIL byte_wr_accesses: got %0d want 1", na); end
      n_checks++; if (mem[16'h0010] !== 8'h5A) begin n_fail++; $display("FAIL byte_wr_mem: got %h want 5a", mem[16'h0010]); end
      @(negedge clk);
      n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL byte_pulse: got v=%b rdy=%b want 0 1", rsp_valid, req_ready); end
      n_checks++; if ({ram_addr, ram_data_in} !== {16'h0010, 8'h5A}) begin n_fail++; $display("FAIL idle_hold: got a=%h di=%h want 0010 5a", ram_addr, ram_data_in); end
      do_req(1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lat, na);
      n_checks++; if ({er, rd} !== {1'b0, 16'h005A}) begin n_fail++; $display("FAIL byte_rd_rsp: got err=%b rdata=%h want 0 005a", er, rd); end
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL byte_rd_latency: got %0d want 4", lat); end
   endtask

   task automatic test_word();
      logic [15:0] rd; logic er; int lat, na;
      ram_wait = 2;
      do_req(1'b1, 1'b1, 16'h0020, 16'hBEEF, rd, er, lat, na);
      n_checks++; if ({er, rd} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL word_wr_rsp: got err=%b rdata=%h want 0 0000", er, rd); end
      n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL word_wr_latency: got %0d want 7", lat); end
      n_checks++; if (na !== 2) begin n_fail++; $display("FAIL word_wr_accesses: got %0d want 2", na); end
      n_checks++; if ({mem[16'h0021], mem[16'h0020]} !== 16'hBEEF) begin n_fail++; $display("FAIL word_wr_mem: got %h%h want beef", mem[16'h0021], mem[16'h0020]); end
      do_req(1'b0, 1'b1, 16'h0020, 16'h0000, rd, er, lat, na);
      n_checks++; if ({er, rd} !== {1'b0, 16'hBEEF}) begin n_fail++; $display("FAIL word_rd_rsp: got err=%b rdata=%h want 0 beef", er, rd); end
      n_checks++; if (na !== 2) begin n_fail++; $display("FAIL word_rd_accesses: got %0d want 2", na); end
   endtask

   task automatic test_wrap();
      logic [15:0] rd; logic er; int lat, na;
      ram_wait = 1;
      do_req(1'b1, 1'b1, 16'hFFFF, 16'h1234, rd, er, lat, na);
      n_checks++; if (last_acc_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_hi_addr: got %h want 0000", last_acc_addr); end
      n_checks++; if ({mem[16'h0000], mem[16'hFFFF]} !== 16'h1234) begin n_fail++; $display("FAIL wrap_mem: got %h%h want 1234", mem[16'h0000], mem[16'hFFFF]); end
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wrap_latency: got %0d want 5", lat); end
      do_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, rd, er, lat, na);
      n_checks++; if ({er, rd} !== {1'b0, 16'h1234}) begin n_fail++; $display("FAIL wrap_rd: got err=%b rdata=%h want 0 1234", er, rd); end
   endtask

   task automatic test_timeout();
      logic [15:0] rd; logic er; int lat, na;
      ram_wait = TO;  // answer arrives in the cycle the limit is reached
      do_req(1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lat, na);
      n_checks++; if ({er, rd} !== {1'b0, 16'h005A}) begin n_fail++; $display("FAIL ready_wins: got err=%b rdata=%h want 0 005a", er, rd); end
      n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL ready_wins_latency: got %0d want 6", lat); end
      ram_wait = 100;
      do_req(1'b1, 1'b0, 16'h0030, 16'h0077, rd, er, lat, na);
      n_checks++; if ({er, rd} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL to_byte_rsp: got err=%b rdata=%h want 1 0000", er, rd); end
      n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL to_byte_latency: got %0d want 6", lat); end
      n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL to_we_low: got %b want 0", ram_we); end
      @(negedge clk);
      n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL to_ready_back: got v=%b rdy=%b want 0 1", rsp_valid, req_ready); end
      do_req(1'b0, 1'b1, 16'h0020, 16'h0000, rd, er, lat, na);
      n_checks++; if ({er, rd, lat, na} !== {1'b1, 16'h0000, 32'd6, 32'd0}) begin n_fail++; $display("FAIL to_word_skip_hi: got err=%b rdata=%h lat=%0d acc=%0d want 1 0000 6 0", er, rd, lat, na); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd; logic er; int lat, na, a0;
      ram_wait = 3;
      a0 = acc_count;
      @(negedge clk);
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_wide = 1'b1; req_addr = 16'h0040; req_wdata = 16'hCAFE;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (acc_count != a0) break;
      end
      @(negedge clk);
      #1;
      n_checks++; if ({ram_we, ram_addr, ram_data_in} !== {1'b1, 16'h0041, 8'hCA}) begin n_fail++; $display("FAIL mid_in_acc_hi: got we=%b a=%h di=%h want 1 0041 ca", ram_we, ram_addr, ram_data_in); end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err, ram_we, rsp_rdata, ram_addr, ram_data_in} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00}) begin
         n_fail++;
         $display("FAIL mid_reset_values: got rdy=%b v=%b e=%b we=%b rd=%h a=%h di=%h want 1 0 0 0 0000 0000 00",
                  req_ready, rsp_valid, rsp_err, ram_we, rsp_rdata, ram_addr, ram_data_in);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got rsp_valid=%b want 0", rsp_valid); end
      end
      n_checks++; if (mem[16'h0040] !== 8'hFE) begin n_fail++; $display("FAIL mid_lo_written: got %h want fe", mem[16'h0040]); end
      ram_wait = 1;
      do_req(1'b0, 1'b0, 16'h0040, 16'h0000, rd, er, lat, na);
      n_checks++; if ({er, rd, lat} !== {1'b0, 16'h00FE, 32'd3}) begin n_fail++; $display("FAIL mid_after_read: got err=%b rdata=%h lat=%0d want 0 00fe 3", er, rd, lat); end
   endtask

   task automatic test_back_to_back();
      int n_rsp, last_c;
      logic prev_v;
      ram_wait = 0;
      n_rsp = 0; last_c = 0; prev_v = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_wide = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0000;
      for (int c = 1; c <= 60 && n_rsp < 4; c++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            n_checks++; if ({prev_v, req_ready} !== 2'b00) begin n_fail++; $display("FAIL b2b_pulse: got prev_v=%b rdy=%b want 0 0", prev_v, req_ready); end
            n_checks++; if (rsp_rdata !== 16'h005A) begin n_fail++; $display("FAIL b2b_rdata: got %h want 005a", rsp_rdata); end
            if (n_rsp > 0) begin
               n_checks++; if (c - last_c !== 3) begin n_fail++; $display("FAIL b2b_period: got %0d want 3", c - last_c); end
            end
            last_c = c;
            n_rsp++;
         end
         prev_v = rsp_valid;
      end
      req_valid = 1'b0;
      n_checks++; if (n_rsp !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", n_rsp); end
      @(negedge clk);
      n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_end: got v=%b rdy=%b want 0 1", rsp_valid, req_ready); end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_wide = 1'b0;
      req_addr = 16'h0000; req_wdata = 16'h0000;
      test_reset();
      test_byte();
      test_word();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      n_checks++;
      if (we_violations !== 0) begin n_fail++; $display("FAIL we_outside_access: got %0d cycles want 0", we_violations); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/test_ram_requester.md
Name: test_ram_requester

Overview:
- Bus initiator that drives the TestRam slave port (clk, we, addr, data_in, data_out, data_ready) on behalf of a CPU-side request interface.
- Accepts byte or 16-bit little-endian word requests. A word is split into two sequential byte accesses: addr, then addr+1.
- Waits on data_ready for each access, returns one response per request, and aborts with an error if the RAM stalls past a timeout.
- Sits between the 65c816 core's memory stage and TestRam. The test bench instantiates it in place of hand-driven RAM stimulus.

Parameters:
- ADDR_WIDTH, 16, RAM address width; must equal the TestRam address width.
- DATA_WIDTH, 8, RAM data width; fixed byte lane.
- TIMEOUT_CYCLES, 255, maximum cycles an access phase waits for ram_data_ready before aborting; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  requester can accept a request; high only in IDLE.
- req_we  input  1  1 = write, 0 = read.
- req_wide  input  1  1 = 16-bit word access, 0 = single byte.
- req_addr  input  ADDR_WIDTH  byte address of the low byte.
- req_wdata  input  16  write data; the low byte goes to addr, the high byte to addr+1.
- rsp_valid  output  1  one-cycle pulse when the request completes.
- rsp_rdata  output  16  read data; {hi, lo} for a word read, {8'h00, lo} for a byte read; 0 for writes.
- rsp_err  output  1  valid with rsp_valid; 1 = timeout abort.
- ram_we  output  1  to TestRam we.
- ram_addr  output  ADDR_WIDTH  to TestRam addr.
- ram_data_in  output  DATA_WIDTH  to TestRam data_in.
- ram_data_out  input  DATA_WIDTH  from TestRam data_out.
- ram_data_ready  input  1  from TestRam data_ready; a one-cycle completion pulse per access.

Behaviour:
- All outputs are registered.
- Reset values (asserted asynchronously, any state, including mid-access):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0;
  - ram_we = 0, ram_addr = 0, ram_data_in = 0;
  - timeout counter = 0.
  - An aborted access produces no response.
- States: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid & req_ready is sampled, latch we, wide, addr, wdata and clear the counter.
  - Next cycle: ram_addr = addr, ram_we = we, ram_data_in = wdata[7:0], req_ready = 0; go to ACC_LO.
- ACC_LO / ACC_HI:
  - ram_addr, ram_we and ram_data_in are held stable for the whole phase.
  - The counter increments each cycle that ram_data_ready = 0.
  - On ram_data_ready = 1 in ACC_LO:
    - capture ram_data_out as lo (reads only) and clear the counter;
    - if wide: next cycle ram_addr = addr+1 (modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000), ram_data_in = wdata[15:8], ram_we unchanged; go to ACC_HI;
    - else: ram_we = 0; go to RESP.
  - On ram_data_ready = 1 in ACC_HI: capture hi, ram_we = 0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without ram_data_ready: ram_we = 0, set the error flag, go to RESP.
    - For a word, this skips ACC_HI when LO times out.
  - ram_data_ready in the same cycle the counter hits the limit counts as success; ready wins.
  - ram_data_ready sampled in IDLE or RESP is ignored.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_err. Reads return the assembled data; writes return rsp_rdata = 0.
  - rsp_err = 1 returns rsp_rdata = 0.
  - Next cycle: IDLE, req_ready = 1.
  - No back-to-back acceptance during RESP.
- Latency, from the acceptance edge to the rsp_valid cycle, with the RAM answering after N cycles per phase:
  - byte: N+2 cycles;
  - word: 2N+3 cycles.
- ram_we is never high outside ACC_LO/ACC_HI.
- ram_addr and ram_data_in retain their last values in IDLE.

Test Plan:
- Byte write 0x5A to 0x0010, then byte read 0x0010 -> rsp_valid once per request, rsp_err = 0; the read returns rsp_rdata = 0x005A.
- Word write 0xBEEF to 0x0020, then word read 0x0020 -> RAM[0x20] = 0xEF, RAM[0x21] = 0xBE; rsp_rdata = 0xBEEF; exactly two RAM accesses per request.
- Word write 0x1234 at 0xFFFF -> the second access goes to ram_addr = 0x0000; a word read at 0xFFFF returns 0x1234.
- Bench model withholds data_ready with TIMEOUT_CYCLES = 4 -> rsp_valid with rsp_err = 1 and rsp_rdata = 0; ram_we is 0 from that point; req_ready returns the next cycle.
- Assert rst mid ACC_HI of a word write -> all outputs immediately at reset values, no rsp_valid; a subsequent byte read completes normally.
- Hold req_valid high continuously -> a request is accepted only when req_ready = 1; no acceptance in RESP; each rsp_valid is a single-cycle pulse.
